// File: rtl/pwm_capture.sv
// pwm_capture: measures servo/RC PWM high times on up to 8 channels in
// 1 us units and exposes them over a zero-wait-state APB3 register file.

// Per-channel capture lane: synchronizer, edge detect, capture FSM,
// width/timeout counters and the VALID/NEW/ERR flags.
module pwm_capture_lane #(
  parameter int MIN_PULSE_US = 500,
  parameter int MAX_PULSE_US = 2500,
  parameter int TIMEOUT_US   = 25000
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        i_en,
  input  logic        i_tick,
  input  logic        i_sync_ok,
  input  logic        i_pwm,
  input  logic        i_clr_new,
  input  logic        i_clr_err,
  output logic [14:0] o_width,
  output logic        o_valid,
  output logic        o_new,
  output logic        o_err
);
  localparam logic [14:0] L_MIN = 15'(MIN_PULSE_US);
  localparam logic [14:0] L_MAX = 15'(MAX_PULSE_US);
  localparam logic [14:0] L_TO  = 15'(TIMEOUT_US);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_WAIT_LOW} state_t;
  state_t r_state, w_state_nxt;

  logic        r_sync1, r_sync2, r_prev, r_armed;
  logic [14:0] r_cnt, r_tcnt, r_width;
  logic        r_valid, r_new, r_err;
  logic        w_rise, w_fall, w_accept, w_err_set;

  // A rising edge only counts once the line has been seen low after reset,
  // so a line that is already high at reset release is ignored.
  assign w_rise = r_armed & r_sync2 & ~r_prev;
  assign w_fall = ~r_sync2 & r_prev;

  // 2-flop synchronizer, edge history and arm flag
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_sync1 <= i_pwm;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (i_sync_ok && !r_sync2) r_armed <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next state plus accept / error decisions
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_err_set   = 1'b0;
    if (!i_en) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     if (w_rise) w_state_nxt = S_HIGH;
        S_HIGH: begin
          if (w_fall) begin
            w_state_nxt = S_IDLE;
            if (r_cnt >= L_MIN && r_cnt <= L_MAX) w_accept  = 1'b1;
            else                                   w_err_set = 1'b1;
          end else if (r_cnt > L_MAX) begin
            w_state_nxt = S_WAIT_LOW;
            w_err_set   = 1'b1;
          end
        end
        S_WAIT_LOW: if (w_fall) w_state_nxt = S_IDLE;
        default:    w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Width counter: cleared on entry to HIGH, counts ticks while HIGH
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)                         r_cnt <= '0;
    else if (!i_en)                       r_cnt <= '0;
    else if (r_state == S_IDLE && w_rise) r_cnt <= '0;
    else if (r_state == S_HIGH && i_tick && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end

  // Timeout counter: restarts on accept, saturates
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)                   r_tcnt <= '0;
    else if (!i_en || w_accept)     r_tcnt <= '0;
    else if (i_tick && r_tcnt != '1) r_tcnt <= r_tcnt + 1'b1;
  end

  // Result flags; a set always beats a coincident clear
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_width <= '0;
      r_valid <= 1'b0;
      r_new   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) r_width <= r_cnt;
      if (!i_en)               r_valid <= 1'b0;
      else if (w_accept)       r_valid <= 1'b1;
      else if (r_tcnt == L_TO) r_valid <= 1'b0;
      if (!i_en)               r_new <= 1'b0;
      else if (w_accept)       r_new <= 1'b1;
      else if (i_clr_new)      r_new <= 1'b0;
      if (w_err_set)           r_err <= 1'b1;
      else if (i_clr_err)      r_err <= 1'b0;
    end
  end

  assign o_width = r_width;
  assign o_valid = r_valid;
  assign o_new   = r_new;
  assign o_err   = r_err;
endmodule

// Top: prescaler, APB register file and the lane array.
module pwm_capture #(
  parameter int NB_OF_CHANNELS = 8,
  parameter int PRESCALER      = 50,
  parameter int MIN_PULSE_US   = 500,
  parameter int MAX_PULSE_US   = 2500,
  parameter int TIMEOUT_US     = 25000
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic                      penable,
  input  logic                      psel,
  input  logic                      pwrite,
  input  logic [15:0]               paddr,
  input  logic [31:0]               pwdata,
  output logic [31:0]               prdata,
  input  logic [NB_OF_CHANNELS-1:0] pwm_in,
  output logic                      irq
);
  localparam int NB = NB_OF_CHANNELS;
  localparam int PW = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;

  logic [PW-1:0]         r_presc;
  logic                  w_tick;
  logic [2:0]            r_vld_pipe;
  logic [NB-1:0]         r_ch_en;
  logic                  r_irq_en, r_irq;
  logic [31:0]           r_prdata, w_rdata;
  logic [NB-1:0]         w_sel_ch, w_clr_new, w_clr_err;
  logic [NB-1:0]         w_valid, w_new, w_err;
  logic [NB-1:0][14:0]   w_width;
  logic [7:0]            w_valid8, w_new8, w_err8, w_en8;
  logic                  w_rd_acc, w_wr, w_is_status, w_is_ctrl, w_is_id;
  logic                  w_unused;

  assign w_tick      = (r_presc == PW'(PRESCALER - 1));
  assign w_rd_acc    = psel & penable & ~pwrite;
  assign w_wr        = psel & penable & pwrite;
  assign w_is_status = (paddr == 16'h0040);
  assign w_is_ctrl   = (paddr == 16'h0044);
  assign w_is_id     = (paddr == 16'h0048);
  assign w_clr_new   = {NB{w_rd_acc}} & w_sel_ch;
  assign w_clr_err   = {NB{w_wr & w_is_status}} & pwdata[16 +: NB];
  assign w_unused    = ^pwdata;

  // Free-running 1 us prescaler
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)    r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + 1'b1;
  end

  // Marks when the synchronizer stages hold real post-reset samples
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) r_vld_pipe <= '0;
    else          r_vld_pipe <= {r_vld_pipe[1:0], 1'b1};
  end

  for (genvar g = 0; g < NB; g++) begin : g_lane
    pwm_capture_lane #(
      .MIN_PULSE_US(MIN_PULSE_US),
      .MAX_PULSE_US(MAX_PULSE_US),
      .TIMEOUT_US  (TIMEOUT_US)
    ) u_lane (
      .pclk     (pclk),
      .presetn  (presetn),
      .i_en     (r_ch_en[g]),
      .i_tick   (w_tick),
      .i_sync_ok(r_vld_pipe[1]),
      .i_pwm    (pwm_in[g]),
      .i_clr_new(w_clr_new[g]),
      .i_clr_err(w_clr_err[g]),
      .o_width  (w_width[g]),
      .o_valid  (w_valid[g]),
      .o_new    (w_new[g]),
      .o_err    (w_err[g])
    );
  end

  // Address decode and read mux; bits for absent channels read 0
  always_comb begin
    w_sel_ch = '0;
    w_valid8 = '0;
    w_new8   = '0;
    w_err8   = '0;
    w_en8    = '0;
    w_rdata  = '0;
    for (int n = 0; n < NB; n++) begin
      w_sel_ch[n] = (paddr == 16'(4 * n));
      w_valid8[n] = w_valid[n];
      w_new8[n]   = w_new[n];
      w_err8[n]   = w_err[n];
      w_en8[n]    = r_ch_en[n];
    end
    if (w_is_status)    w_rdata = {8'h00, w_err8, w_new8, w_valid8};
    else if (w_is_ctrl) w_rdata = {23'h0, r_irq_en, w_en8};
    else if (w_is_id)   w_rdata = 32'h5057_4D43;
    else begin
      for (int n = 0; n < NB; n++)
        if (w_sel_ch[n]) w_rdata = {15'h0, w_valid[n], 1'b0, w_width[n]};
    end
  end

  // CONTROL register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_ch_en  <= '1;
      r_irq_en <= 1'b0;
    end else if (w_wr && w_is_ctrl) begin
      r_ch_en  <= pwdata[NB-1:0];
      r_irq_en <= pwdata[8];
    end
  end

  // Registered read data and interrupt
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_prdata <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (psel && !pwrite) r_prdata <= w_rdata;
      r_irq <= r_irq_en & (|(w_new | w_err));
    end
  end

  assign prdata = r_prdata;
  assign irq    = r_irq;
endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with a scaled-down timebase
// (2 pclk per us, pulse window 20..60 us, timeout 200 us).
module tb_pwm_capture;
  logic        pclk = 1'b0, presetn = 1'b0;
  logic        penable = 1'b0, psel = 1'b0, pwrite = 1'b0;
  logic [15:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic [7:0]  pwm_in = '0;
  logic        irq;
  int          n_cmp = 0, n_fail = 0;
  logic [31:0] rd;

  pwm_capture #(
    .NB_OF_CHANNELS(8), .PRESCALER(2), .MIN_PULSE_US(20),
    .MAX_PULSE_US(60), .TIMEOUT_US(200)
  ) dut (
    .pclk(pclk), .presetn(presetn), .penable(penable), .psel(psel),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pwm_in(pwm_in), .irq(irq)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag, input logic [31:0] obs, input int lo, input int hi);
    n_cmp++;
    assert (int'(obs[14:0]) >= lo && int'(obs[14:0]) <= hi) else begin
      n_fail++;
      $error("FAIL %s: got width %0d want %0d..%0d", tag, obs[14:0], lo, hi);
    end
  endtask

  // all helpers start and end 1 time unit after a rising edge
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic apb_read(input logic [15:0] a, output logic [31:0] d);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
    wait_cyc(1);
    penable = 1'b1;
    wait_cyc(1);
    d = prdata; psel = 1'b0; penable = 1'b0;
  endtask

  task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    wait_cyc(1);
    penable = 1'b1;
    wait_cyc(1);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] mask, input int cyc);
    pwm_in = pwm_in | mask;
    wait_cyc(cyc);
    pwm_in = pwm_in & ~mask;
    wait_cyc(6);
  endtask

  initial begin
    // reset state
    #3;
    check("rst_prdata", prdata, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    @(posedge pclk); #1;
    presetn = 1'b1;
    wait_cyc(4);
    apb_read(16'h0044, rd); check("ctrl_rst", rd, 32'h0000_00FF);
    apb_read(16'h0048, rd); check("id", rd, 32'h5057_4D43);
    apb_read(16'h0040, rd); check("status_rst", rd, 32'h0);
    apb_read(16'h0000, rd); check("ch0_rst", rd, 32'h0);
    apb_write(16'h004C, 32'hFFFF_FFFF);
    apb_read(16'h004C, rd); check("unmapped", rd, 32'h0);

    // nominal 30 us pulse on ch0
    pulse(8'h01, 60);
    apb_read(16'h0040, rd); check("status_acc", rd, 32'h0000_0101);
    check("irq_off", {31'h0, irq}, 32'h0);
    apb_write(16'h0044, 32'h0000_01FF);
    wait_cyc(1);
    check("irq_on", {31'h0, irq}, 32'h1);
    apb_read(16'h0000, rd);
    check("ch0_flags", rd & 32'hFFFF_8000, 32'h0001_0000);
    check_w("ch0_w30", rd, 29, 31);
    apb_read(16'h0040, rd); check("new_clr", rd & 32'h0001_0101, 32'h0000_0001);
    check("irq_clr", {31'h0, irq}, 32'h0);

    // accept lands on the same edge as a CH_WIDTH_0 access phase
    pwm_in[0] = 1'b1;
    wait_cyc(60);
    pwm_in[0] = 1'b0;
    wait_cyc(1);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = 16'h0000;
    wait_cyc(1);
    penable = 1'b1;
    wait_cyc(1);
    psel = 1'b0; penable = 1'b0;
    wait_cyc(2);
    apb_read(16'h0040, rd); check("new_set_wins", rd & 32'h100, 32'h100);
    apb_read(16'h0000, rd); // consume NEW

    // too-short pulse: error, width kept
    pulse(8'h01, 10);
    apb_read(16'h0040, rd); check("err_short", rd & 32'h0001_0100, 32'h0001_0000);
    apb_read(16'h0000, rd); check_w("ch0_keep_short", rd, 29, 31);
    apb_write(16'h0040, 32'h0001_0000);
    apb_read(16'h0040, rd); check("err_w1c", rd & 32'h0001_0000, 32'h0);

    // overlong pulse: error raised while still high, no update
    pwm_in[0] = 1'b1;
    wait_cyc(140);
    apb_read(16'h0040, rd); check("err_long_high", rd & 32'h0001_0000, 32'h0001_0000);
    wait_cyc(20);
    pwm_in[0] = 1'b0;
    wait_cyc(6);
    apb_read(16'h0040, rd); check("long_no_new", rd & 32'h0001_0100, 32'h0001_0000);
    apb_read(16'h0000, rd); check_w("ch0_keep_long", rd, 29, 31);
    apb_write(16'h0040, 32'h0001_0000);

    // 40 us pulse, then timeout
    pulse(8'h01, 80);
    apb_read(16'h0000, rd);
    check("ch0_v40", rd & 32'hFFFF_8000, 32'h0001_0000);
    check_w("ch0_w40", rd, 39, 41);
    wait_cyc(300);
    apb_read(16'h0040, rd); check("valid_before_to", rd & 32'h1, 32'h1);
    wait_cyc(120);
    apb_read(16'h0040, rd); check("valid_after_to", rd & 32'h1, 32'h0);
    apb_read(16'h0000, rd);
    check("ch0_to_flags", rd & 32'hFFFF_8000, 32'h0);
    check_w("ch0_to_w", rd, 39, 41);

    // disable ch0 while ch1 keeps running
    pulse(8'h01, 60);
    apb_write(16'h0044, 32'h0000_01FE);
    apb_read(16'h0044, rd); check("ctrl_rb", rd, 32'h0000_01FE);
    apb_read(16'h0040, rd); check("dis_clear", rd & 32'h0001_0101, 32'h0);
    pulse(8'h03, 60);
    apb_read(16'h0040, rd); check("dis_ch1_only", rd & 32'h0001_0303, 32'h0000_0202);
    apb_read(16'h0004, rd); check_w("ch1_w30", rd, 29, 31);

    // reset in the middle of a pulse, released while still high
    apb_write(16'h0044, 32'h0000_01FF);
    pwm_in[0] = 1'b1;
    wait_cyc(20);
    presetn = 1'b0;
    #1;
    check("mid_rst_prdata", prdata, 32'h0);
    check("mid_rst_irq", {31'h0, irq}, 32'h0);
    wait_cyc(3);
    presetn = 1'b1;
    wait_cyc(40);
    pwm_in[0] = 1'b0;
    wait_cyc(6);
    apb_read(16'h0040, rd); check("rst_discard", rd, 32'h0);
    pulse(8'h01, 60);
    apb_read(16'h0040, rd); check("rst_next_acc", rd, 32'h0000_0101);
    check("irq_dis_rst", {31'h0, irq}, 32'h0);
    apb_read(16'h0044, rd); check("ctrl_rst2", rd, 32'h0000_00FF);
    apb_read(16'h0048, rd); check("id2", rd, 32'h5057_4D43);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
